// File: rtl/vga_scan.sv
// rtl/vga_scan.sv - 640x480 raster timing generator, 2 clocks per pixel, VGA sync/blank/RGB drive.
// Optional output alignment register stage: VGA_SCAN_ALIGN_EN.
module vga_scan #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 29
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] color,
    output logic [8:0]  row,
    output logic [9:0]  col,
    output logic        blank,
    output logic        pix_en,
    output logic        frame_start,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(2 * H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_VIS_P    = 10'(H_VIS);
    localparam logic [9:0]  HS_FIRST   = 10'(H_VIS + H_FP);
    localparam logic [9:0]  HS_LAST    = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_VIS_L    = 10'(V_VIS);
    localparam logic [9:0]  VS_FIRST   = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_LAST    = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic [9:0]  hp;
    logic        blank_c;
    logic        hs_act;
    logic        vs_act;
    logic        blank_out;

    always_comb begin
        hcount_d = hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = 11'd0;
            vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hcount_q <= 11'd0;
            vcount_q <= 10'd0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign hp      = hcount_q[10:1];
    assign blank_c = (hp >= H_VIS_P) | (vcount_q >= V_VIS_L);
    assign hs_act  = (hp >= HS_FIRST) && (hp <= HS_LAST);
    assign vs_act  = (vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST);

    assign row         = vcount_q[8:0];
    assign col         = hp;
    assign blank       = blank_c;
    assign pix_en      = ~hcount_q[0];
    // Counters sit at (0,0) during reset; the pulse belongs to the first running clock only.
    assign frame_start = (hcount_q == 11'd0) && (vcount_q == 10'd0) && !reset;

`ifdef VGA_SCAN_ALIGN_EN
    logic hs_q;
    logic vs_q;
    logic blank_n_q;

    // One-clock lag matches the colour logic's registered output.
    always_ff @(posedge clock) begin
        if (reset) begin
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            hs_q      <= ~hs_act;
            vs_q      <= ~vs_act;
            blank_n_q <= ~blank_c;
        end
    end

    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign blank_out   = ~blank_n_q;
`else
    assign vga_hs      = ~hs_act | reset;
    assign vga_vs      = ~vs_act | reset;
    assign blank_out   = blank_c | reset;
    assign vga_blank_n = ~blank_out;
`endif

    assign {vga_r, vga_g, vga_b} = blank_out ? 24'h000000 : color;

endmodule

// File: tb/tb_vga_scan.sv
// tb/tb_vga_scan.sv - directed self-checking bench for vga_scan (short vertical timing, full line timing).
module tb_vga_scan;

    localparam int V_VIS  = 12;
    localparam int V_FP   = 2;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 3;
    localparam int LINE   = 1600;
    localparam int V_TOT  = 19;
    localparam int FRAME  = 30400;
`ifdef VGA_SCAN_ALIGN_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic        clk;
    logic        reset;
    logic [23:0] color;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        blank;
    logic        pix_en;
    logic        frame_start;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic [23:0] rgb;

    int n_cmp;
    int n_bad;

    assign rgb = {vga_r, vga_g, vga_b};

    vga_scan #(
        .V_VIS  (V_VIS),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) dut (
        .clock       (clk),
        .reset       (reset),
        .color       (color),
        .row         (row),
        .col         (col),
        .blank       (blank),
        .pix_en      (pix_en),
        .frame_start (frame_start),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string pfx);
        check_eq({pfx, "_row"}, 32'(row), 32'd0);
        check_eq({pfx, "_col"}, 32'(col), 32'd0);
        check_eq({pfx, "_blank"}, 32'(blank), 32'd0);
        check_eq({pfx, "_pix_en"}, 32'(pix_en), 32'd1);
        check_eq({pfx, "_frame_start"}, 32'(frame_start), 32'd0);
        check_eq({pfx, "_hs"}, 32'(vga_hs), 32'd1);
        check_eq({pfx, "_vs"}, 32'(vga_vs), 32'd1);
        check_eq({pfx, "_blank_n"}, 32'(vga_blank_n), 32'd0);
        check_eq({pfx, "_rgb"}, 32'(rgb), 32'd0);
    endtask

    initial begin
        int col_err, row_err, pix_err, blank_err, bn_err, rgb_err;
        int hs_first, hs_cnt, vs_first, vs_cnt, fs_cnt, vblank_cnt;
        int eh, ev;
        logic eblank, prev_blank, used_blank;

        n_cmp = 0;
        n_bad = 0;
        col_err = 0; row_err = 0; pix_err = 0; blank_err = 0; bn_err = 0; rgb_err = 0;
        hs_first = -1; hs_cnt = 0; vs_first = -1; vs_cnt = 0; fs_cnt = 0; vblank_cnt = 0;
        reset = 1'b1;
        color = 24'hFFFF00;
        tick();
        tick();
        check_reset_state("reset");

        reset = 1'b0;
        #1;
        prev_blank = 1'b1;
        for (int gc = 0; gc <= FRAME; gc++) begin
            if (gc > 0) tick();
            eh     = gc % LINE;
            ev     = (gc / LINE) % V_TOT;
            eblank = (eh >= 1280) || (ev >= V_VIS);
            used_blank = (LAT == 1) ? prev_blank : eblank;

            if (32'(col) != 32'(eh / 2)) col_err++;
            if (32'(row) != 32'(ev)) row_err++;
            if (pix_en != ((eh % 2) == 0)) pix_err++;
            if (blank != eblank) blank_err++;
            if (vga_blank_n != !used_blank) bn_err++;
            if (rgb != (used_blank ? 24'h0 : 24'hFFFF00)) rgb_err++;
            if (frame_start) fs_cnt++;
            if (gc < FRAME && ev >= V_VIS && blank) vblank_cnt++;
            if (gc < LINE && !vga_hs) begin
                if (hs_first < 0) hs_first = gc;
                hs_cnt++;
            end
            if (gc < FRAME && !vga_vs) begin
                if (vs_first < 0) vs_first = gc;
                vs_cnt++;
            end

            if (gc == 0)       check_eq("fs_first_clock", 32'(frame_start), 32'd1);
            if (gc == 1)       check_eq("fs_single_clock", 32'(frame_start), 32'd0);
            if (gc == 1599)    check_eq("col_799", 32'(col), 32'd799);
            if (gc == LINE)    check_eq("row_at_1600", 32'(row), 32'd1);
            if (gc == LINE)    check_eq("col_at_1600", 32'(col), 32'd0);
            if (gc == FRAME)   check_eq("fs_at_frame", 32'(frame_start), 32'd1);
            if (gc == FRAME)   check_eq("row_at_frame", 32'(row), 32'd0);
            prev_blank = eblank;
        end
        check_eq("col_ramp_errs", 32'(col_err), 32'd0);
        check_eq("row_errs", 32'(row_err), 32'd0);
        check_eq("pix_en_errs", 32'(pix_err), 32'd0);
        check_eq("blank_errs", 32'(blank_err), 32'd0);
        check_eq("blank_n_errs", 32'(bn_err), 32'd0);
        check_eq("rgb_yellow_errs", 32'(rgb_err), 32'd0);
        check_eq("hs_start", 32'(hs_first), 32'(1312 + LAT));
        check_eq("hs_len", 32'(hs_cnt), 32'd192);
        check_eq("vs_start", 32'(vs_first), 32'(22400 + LAT));
        check_eq("vs_len", 32'(vs_cnt), 32'd3200);
        check_eq("fs_count", 32'(fs_cnt), 32'd2);
        check_eq("vblank_lines", 32'(vblank_cnt), 32'd11200);

        // Mid-frame reset at line 5, hcount 777.
        repeat (8777) tick();
        check_eq("pre_reset_row", 32'(row), 32'd5);
        check_eq("pre_reset_col", 32'(col), 32'd388);
        check_eq("pre_reset_pix_en", 32'(pix_en), 32'd0);
        reset = 1'b1;
        tick();
        check_reset_state("midreset");
        reset = 1'b0;
        #1;
        check_eq("fs_after_release", 32'(frame_start), 32'd1);

        color = 24'h0;
        repeat (16040) tick();
        check_eq("inject_row", 32'(row), 32'd10);
        check_eq("inject_col", 32'(col), 32'd20);
        check_eq("inject_pix_en", 32'(pix_en), 32'd1);
        for (int k = 0; k < 3; k++) begin
            color = (k == LAT) ? 24'h123456 : 24'h0;
            #1;
            check_eq($sformatf("inject_rgb_%0d", k), 32'(rgb), (k == LAT) ? 32'h123456 : 32'h0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_scan.md
# vga_scan

Raster timing generator for the 640x480 display path. It runs on the 50 MHz system clock with each pixel lasting 2 clocks, and produces the `row`/`col` scan coordinates consumed by the pixel-colour logic. It takes that logic's registered 24-bit `color` back and drives the VGA connector: sync, blanking and 8-bit R/G/B. One frame is 1600 x 521 = 833600 clocks, the same period the game's frame-tick counters assume.

## Interface
Parameters:
- H_VIS, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_VIS, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 29: vertical back porch, in lines.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high.
- color  in  24  pixel colour {R,G,B}, registered one clock after `row`/`col` by the colour logic.
- row  out  9  current line, vcount[8:0].
- col  out  10  current pixel, hcount[10:1].
- blank  out  1  high outside the visible region (cycle-0 decode).
- pix_en  out  1  high on the first clock of each pixel (hcount[0]==0).
- frame_start  out  1  one-clock pulse when hcount==0 and vcount==0.
- vga_hs  out  1  horizontal sync, active low.
- vga_vs  out  1  vertical sync, active low.
- vga_blank_n  out  1  low while blanked.
- vga_r, vga_g, vga_b  out  8 each  colour to the DAC.

## Operation
- hcount is 11 bits and counts 0..1599 in clocks; at 1599 it wraps to 0.
- vcount is 10 bits and advances when hcount wraps; it counts 0..520, and at 520 (with hcount at 1599) it wraps to 0.
- Pixel index hp = hcount>>1, range 0..799.
- blank = (hp >= 640) | (vcount >= 480).
- HS is active when 656 <= hp <= 751.
- VS is active when 490 <= vcount <= 491 (entire lines).
- `col` = hp, so it reaches 799 during blanking.
- `row` = vcount[8:0], so lines 512..520 alias to 0..8. `row`/`col` are meaningful only when blank==0; consumers gate with blank.
- RGB output = blank_out ? 0 : color. blank_out is the blank term aligned per Configuration.
- frame_start, pix_en, row, col and blank are combinational decodes of the counter registers and are never delayed.
- All boundaries derive from the parameters: H total = sum of the four H_* parameters, V total = sum of the four V_* parameters.

## Timing
- Reset values, asserted on the clock after reset is sampled high and held while reset is high:
  - hcount = 0, vcount = 0.
  - row = 0, col = 0, blank = 0.
  - pix_en = 1, frame_start = 0 (suppressed during reset).
  - vga_hs = 1, vga_vs = 1, vga_blank_n = 0, RGB = 0.
- The first clock after reset deasserts is hcount = 0, vcount = 0, and frame_start pulses there.
- Reset mid-frame aborts the frame and restarts it from (0,0). There is no partial-line completion.
- Line wrap and frame wrap on the same clock (hcount = 1599, vcount = 520): both counters go to 0 on the next clock.
- HS low lasts 192 clocks, starting at hcount 1312.
- VS low lasts 3200 clocks, starting at vcount 490, hcount 0.
- frame_start period: 833600 clocks.

## Configuration
- Macro: VGA_SCAN_ALIGN_EN.
- Defined:
  - vga_hs, vga_vs and vga_blank_n are registered, so they lag the counters by 1 clock.
  - The RGB gate uses the registered blank, matching the colour logic's 1-clock `color` register.
  - The pixel at (row,col) appears on vga_* exactly 1 clock after row/col present it.
- Undefined:
  - The sync and blank outputs are combinational decodes of the current counters, with 0-clock latency.
  - The RGB gate uses the current blank.
  - Intended for combinational colour sources.

## Test plan
- Reset, then run 1600 clocks -> col steps 0..799, two clocks per value; row goes 0->1 at clock 1600; pix_en toggles every clock.
- Run one line -> vga_hs low for exactly 192 clocks, starting at hcount 1312.
- Run one frame -> vga_vs low for exactly 3200 clocks, starting at vcount 490; frame_start pulses at clock 0 and clock 833600; blank is high for all of lines 480..520.
- Hold color = 24'hFFFF00 throughout -> RGB = FF/FF/00 in the visible region and 0 whenever blank; with VGA_SCAN_ALIGN_EN, the first non-zero RGB of a line lags col = 0 by 1 clock.
- Assert reset for 1 clock at vcount = 300, hcount = 777 -> next clock hcount = 0, vcount = 0, outputs at reset values; frame_start pulses on the first clock after release.
- Drive color = 24'h123456 for a single clock at visible (row 10, col 20) -> without the macro it appears at that clock; with the macro it appears 1 clock later; other pixels show 0 if color is 0 elsewhere.
